// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared widths, types and coefficient table for the 31-tap symmetric
// low-pass FIR (fir_filter).
//
// Contents:
//   DATA_W / COEF_W / TAPS / ACC_W  : datapath sizing
//   sample_t                        : signed input/output sample type
//   COEFFS                          : Q1.15 Hamming-windowed sinc, cutoff fs/8
//
// Coefficient derivation: h[n] = sin(pi*m/4)/(pi*m) * (0.54 + 0.46*cos(pi*m/15)),
// m = n - 15, rounded to Q1.15. The centre tap is then set to
// 32768 - sum(other taps), so the DC gain is exactly 1.0.
// -----------------------------------------------------------------------------
package fir_pkg;

   localparam int DATA_W = 16;
   localparam int COEF_W = 16;
   localparam int TAPS   = 31;
   localparam int ACC_W  = 38;

   // Number of pre-added tap pairs; the centre tap sits at index HALF.
   localparam int HALF   = (TAPS - 1) / 2;
   localparam int PRE_W  = DATA_W + 1;
   localparam int PROD_W = PRE_W + COEF_W;
   localparam int FRAC_W = COEF_W - 1;

   typedef logic signed [DATA_W-1:0] sample_t;
   typedef logic signed [COEF_W-1:0] coef_t;
   typedef logic signed [PRE_W-1:0]  pre_t;
   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   localparam coef_t COEFFS [TAPS] = '{
      -16'sd39,   -16'sd67,   -16'sd68,    16'sd0,
       16'sd156,   16'sd323,   16'sd326,   16'sd0,
      -16'sd620,  -16'sd1186, -16'sd1136,  16'sd0,
       16'sd2242,  16'sd5008,  16'sd7301,  16'sd8288,
       16'sd7301,  16'sd5008,  16'sd2242,  16'sd0,
      -16'sd1136, -16'sd1186, -16'sd620,   16'sd0,
       16'sd326,   16'sd323,   16'sd156,   16'sd0,
      -16'sd68,   -16'sd67,   -16'sd39
   };

endpackage

// File: rtl/fir_filter_if.sv
// -----------------------------------------------------------------------------
// fir_filter_if
// Sample-stream bundle between a sample source (master) and fir_filter (slave).
//
// Signals:
//   clk_en     : source -> filter, advance one sample this clock
//   filter_in  : source -> filter, signed sample
//   filter_out : filter -> source, registered filtered sample
//
// Handshake: clk_en acts as a valid qualifier with no ready path. filter_in is
// consumed on every rising edge where clk_en=1 and is ignored otherwise; the
// filter never stalls the source, and while clk_en=0 filter_out holds.
// -----------------------------------------------------------------------------
interface fir_filter_if;
   import fir_pkg::*;

   logic    clk_en;
   sample_t filter_in;
   sample_t filter_out;

   modport master (output clk_en, output filter_in, input  filter_out);
   modport slave  (input  clk_en, input  filter_in, output filter_out);

endinterface

// File: rtl/fir_round_sat.sv
// -----------------------------------------------------------------------------
// fir_round_sat
// Converts the full-precision accumulator back to a 16-bit sample: round half
// up at the Q1.15 point, then either clamp or wrap.
//
// Ports:
//   acc_in : ACC_W signed accumulator (sum of all tap products)
//   y_out  : DATA_W signed result
//
// Build option FIR_SATURATE_EN:
//   defined   -> clamp to [-32768, 32767]
//   undefined -> keep the low DATA_W bits (two's-complement wrap)
// -----------------------------------------------------------------------------
module fir_round_sat
   import fir_pkg::*;
(
   input  acc_t    acc_in,
   output sample_t y_out
);

   localparam int   SH_W     = ACC_W - FRAC_W;
   localparam acc_t RND_HALF = acc_t'(1 << (FRAC_W - 1));

   typedef logic signed [SH_W-1:0] shifted_t;

   acc_t     rnd;
   shifted_t shifted;

   always_comb begin
      rnd     = acc_in + RND_HALF;
      shifted = shifted_t'(rnd >>> FRAC_W);
`ifdef FIR_SATURATE_EN
      // In range only if every bit above the 16-bit sign bit matches it.
      if ((&shifted[SH_W-1:DATA_W-1]) || !(|shifted[SH_W-1:DATA_W-1])) begin
         y_out = sample_t'(shifted);
      end else if (shifted[SH_W-1]) begin
         y_out = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         y_out = {1'b0, {(DATA_W-1){1'b1}}};
      end
`else
      y_out = sample_t'(shifted);
`endif
   end

endmodule

// File: rtl/fir_filter.sv
// -----------------------------------------------------------------------------
// fir_filter
// 31-tap symmetric linear-phase low-pass FIR, one sample per enabled clock.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears all state, overrides clk_en
//   bus   : fir_filter_if.slave (clk_en, filter_in, filter_out)
//
// Pipeline (all stages advance only when clk_en=1):
//   stage 1  x_q   : delay line, x[0] newest
//   stage 2  m_q   : pre-added, multiplied tap pairs plus centre tap
//   stage 3  out_q : adder tree -> round -> saturate/wrap
// A sample captured at enabled edge n first reaches filter_out at edge n+2.
//
// Build option FIR_SATURATE_EN selects clamping in fir_round_sat.
// -----------------------------------------------------------------------------
module fir_filter
   import fir_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   fir_filter_if.slave bus
);

   sample_t x_q [TAPS];
   sample_t x_d [TAPS];
   prod_t   m_q [HALF+1];
   prod_t   m_d [HALF+1];
   sample_t out_q;
   sample_t out_d;

   acc_t    acc;
   sample_t rounded;

   // Delay line.
   always_comb begin
      x_d = x_q;
      if (bus.clk_en) begin
         x_d[0] = bus.filter_in;
         for (int i = 1; i < TAPS; i++) begin
            x_d[i] = x_q[i-1];
         end
      end
   end

   // Symmetric pre-add then multiply: taps k and TAPS-1-k share h[k],
   // so only HALF multipliers plus the centre tap are needed.
   always_comb begin
      m_d = m_q;
      if (bus.clk_en) begin
         for (int k = 0; k < HALF; k++) begin
            m_d[k] = prod_t'(pre_t'(x_q[k]) + pre_t'(x_q[TAPS-1-k]))
                   * prod_t'(COEFFS[k]);
         end
         m_d[HALF] = prod_t'(x_q[HALF]) * prod_t'(COEFFS[HALF]);
      end
   end

   // Full-width sum of the registered products; the accumulator is wide
   // enough that no intermediate truncation is ever needed.
   always_comb begin
      acc = '0;
      for (int k = 0; k <= HALF; k++) begin
         acc = acc + acc_t'(m_q[k]);
      end
   end

   fir_round_sat u_round_sat (
      .acc_in (acc),
      .y_out  (rounded)
   );

   always_comb begin
      out_d = out_q;
      if (bus.clk_en) begin
         out_d = rounded;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) begin
            x_q[i] <= '0;
         end
         for (int k = 0; k <= HALF; k++) begin
            m_q[k] <= '0;
         end
         out_q <= '0;
      end else begin
         x_q   <= x_d;
         m_q   <= m_d;
         out_q <= out_d;
      end
   end

   assign bus.filter_out = out_q;

endmodule

// File: tb/tb_fir_filter.sv
// -----------------------------------------------------------------------------
// tb_fir_filter
// Self-checking bench for fir_filter. Holds its own copy of the coefficient
// table and a direct-form reference model (plain 31-term convolution with the
// documented two-edge pipeline latency). Expected outputs go through exp_q.
// Honours FIR_SATURATE_EN for the saturation expectation.
// -----------------------------------------------------------------------------
module tb_fir_filter;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fir_filter_if bus ();

   fir_filter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- reference data ----------------
   int h_ref [31] = '{
      -39, -67, -68, 0, 156, 323, 326, 0, -620, -1186, -1136, 0,
      2242, 5008, 7301, 8288, 7301, 5008, 2242, 0, -1136, -1186, -620, 0,
      326, 323, 156, 0, -68, -67, -39
   };

`ifdef FIR_SATURATE_EN
   localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
   localparam logic [15:0] SAT_EXP = 16'hB0AF;
`endif

   typedef struct {
      logic [15:0] din;
      logic [15:0] exp;
   } vec_t;

   vec_t imp_tab [40];

   // ---------------- scoreboard ----------------
   logic [15:0] exp_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;

   // ---------------- reference model state ----------------
   longint      mx [31];
   longint      macc;
   logic [15:0] mout;

   function automatic logic [15:0] round_sat_ref(input longint a);
      longint r;
      r = (a + 64'sd16384) >>> 15;
`ifdef FIR_SATURATE_EN
      if (r > 64'sd32767)  r = 64'sd32767;
      if (r < -64'sd32768) r = -64'sd32768;
`endif
      return r[15:0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 31; i++) mx[i] = 0;
      macc = 0;
      mout = '0;
   endtask

   task automatic model_step(input logic [15:0] din, input logic en, input logic rn);
      longint s;
      if (!rn) begin
         model_reset();
      end else if (en) begin
         mout = round_sat_ref(macc);
         s = 0;
         for (int i = 0; i < 31; i++) s += mx[i] * longint'(h_ref[i]);
         macc = s;
         for (int i = 30; i > 0; i--) mx[i] = mx[i-1];
         mx[0] = longint'($signed(din));
      end
   endtask

   // ---------------- checker / driver ----------------
   task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s @%0t: filter_out=%h required=%h", name, $time, act, expv);
      end
   endtask

   // Drive one clock of stimulus, push the model's expectation, compare #1
   // after the edge.
   task automatic step(input string name, input logic [15:0] din,
                       input logic en, input logic rn);
      bus.filter_in = din;
      bus.clk_en    = en;
      rst_n         = rn;
      model_step(din, en, rn);
      exp_q.push_back(mout);
      @(posedge clk);
      #1;
      check(name, bus.filter_out, exp_q.pop_front());
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   logic        en_c;
   logic [15:0] din_c;
   int          e;

   initial begin
      model_reset();
      rst_n         = 1'b0;
      bus.clk_en    = 1'b1;
      bus.filter_in = 16'h1234;

      // Impulse table: 16384 then zeros -> floor((h[k]+1)/2) from edge 2.
      for (int i = 0; i < 40; i++) begin
         imp_tab[i].din = (i == 0) ? 16'd16384 : 16'd0;
         imp_tab[i].exp = 16'd0;
         if (i >= 2 && i <= 32) imp_tab[i].exp = 16'((h_ref[i-2] + 1) >>> 1);
      end

      // Reset held two edges with nonzero input, then first enabled edge.
      for (int i = 0; i < 2; i++) begin
         step("reset_hold", 16'h1234, 1'b1, 1'b0);
         check("reset_zero", bus.filter_out, 16'h0000);
      end
      step("reset_release", 16'h1234, 1'b1, 1'b1);
      check("reset_release_zero", bus.filter_out, 16'h0000);

      // Let the captured 0x1234 sample play out against the model.
      for (int i = 0; i < 40; i++) step("flush_1234", 16'h0000, 1'b1, 1'b1);

      // Impulse response, table driven.
      for (int i = 0; i < 40; i++) begin
         step("impulse", imp_tab[i].din, 1'b1, 1'b1);
         check("impulse_tab", bus.filter_out, imp_tab[i].exp);
      end

      // Impulse with clk_en low for 5 cycles mid-response; input is noise
      // while disabled and must be ignored.
      e = 0;
      for (int c = 0; c < 45; c++) begin
         en_c  = (c >= 12 && c < 17) ? 1'b0 : 1'b1;
         din_c = (c == 0) ? 16'd16384 : 16'd0;
         if (!en_c) din_c = 16'($urandom_range(0, 65535));
         step("gate", din_c, en_c, 1'b1);
         if (en_c) e++;
         check("gate_tab", bus.filter_out, imp_tab[e-1].exp);
      end

      // DC step response: unity gain once the line is full.
      for (int i = 1; i <= 40; i++) begin
         step("dc", 16'd1000, 1'b1, 1'b1);
         if (i >= 33) check("dc_steady", bus.filter_out, 16'd1000);
      end

      // Reset pulse during DC with clk_en high: reset wins.
      step("mid_reset", 16'd1000, 1'b1, 1'b0);
      check("mid_reset_zero", bus.filter_out, 16'h0000);
      for (int i = 1; i <= 36; i++) begin
         step("dc_restart", 16'd1000, 1'b1, 1'b1);
         if (i <= 2)  check("dc_restart_zero", bus.filter_out, 16'h0000);
         if (i >= 33) check("dc_restart_steady", bus.filter_out, 16'd1000);
      end

      // Saturation: fill the line with full-scale values matching sign(h).
      step("sat_clear", 16'h0000, 1'b1, 1'b0);
      for (int j = 0; j < 31; j++) begin
         din_c = (h_ref[j] >= 0) ? 16'h7FFF : 16'h8000;
         step("sat_fill", din_c, 1'b1, 1'b1);
      end
      step("sat_tail", 16'h0000, 1'b1, 1'b1);
      step("sat_tail", 16'h0000, 1'b1, 1'b1);
      check("sat_value", bus.filter_out, SAT_EXP);
      step("sat_hold", 16'h0000, 1'b0, 1'b1);
      check("sat_hold_value", bus.filter_out, SAT_EXP);

      // Reset with clk_en low still clears, and nothing stale re-emerges.
      step("rst_no_en", 16'h5555, 1'b0, 1'b0);
      check("rst_no_en_zero", bus.filter_out, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         step("post_reset", 16'h0000, 1'b1, 1'b1);
         check("post_reset_zero", bus.filter_out, 16'h0000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_filter.md
# fir_filter

Fixed-coefficient, 31-tap symmetric linear-phase low-pass FIR filter for 16-bit signed two's-complement samples at one sample per enabled clock. It sits in the sample datapath between the signal source and downstream processing. Samples are accepted on every clock where `clk_en` is high. Internally it is a delay line, symmetric pre-add, parallel multiply and adder tree, followed by rounding and saturation back to 16 bits.

## Interface
- `DATA_W`, 16: input/output sample width, signed.
- `COEF_W`, 16: coefficient width, signed Q1.15.
- `TAPS`, 31: number of taps; must be odd (symmetric, one centre tap).
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `clk_en` input 1: when high, the filter advances one sample this cycle; when low, all state holds.
- `filter_in` input 16: signed input sample, captured on a rising edge with `clk_en`=1.
- `filter_out` output 16: signed filtered sample, registered.

## Operation
- Reset (`rst_n`=0 at a rising edge) clears all state regardless of `clk_en`: delay line, pipeline registers and `filter_out` become 0.
- Delay line: x[0..TAPS-1]. On an enabled edge, x[0] takes `filter_in` and x[i] takes x[i-1].
- Pre-add: p[k] = x[k] + x[TAPS-1-k] for k < (TAPS-1)/2, 17 bits signed. The centre tap uses x[(TAPS-1)/2] directly.
- Multiply: m[k] = p[k]·h[k] gives a 33-bit signed product. Results are registered.
- Accumulate: sum all 16 products in a 38-bit signed adder tree, with no intermediate truncation.
- Round: add 2^14, then arithmetic shift right by 15 (round half up).
- Output: the result is saturated (see Configuration) to 16 bits and registered into `filter_out`.
- Coefficients h[0..30]:
  - Symmetric: h[k] = h[30-k].
  - Hamming-windowed sinc, cutoff fs/8, quantized to Q1.15.
  - The centre tap is adjusted so that Σh = 32768 exactly (unity DC gain).
- `clk_en` low: no register changes. Pipeline contents are frozen and resume unchanged when `clk_en` returns high.

## Timing
- Pipeline has 3 register stages: delay line, product, output.
- A sample captured at enabled edge n first contributes to `filter_out` at enabled edge n+2, weighted by h[0].
- Group delay: 15 samples plus 2 enabled edges of pipeline latency.
- After reset, `filter_out` stays 0 until nonzero input propagates.
- Reset asserted mid-stream: the next edge zeroes everything. The output is 0 until new samples arrive, and no stale samples survive.
- Reset and `clk_en` asserted together: reset wins.

## Configuration
- `FIR_SATURATE_EN` defined: the rounded result is clamped to [-32768, 32767]. Out-of-range values yield 16'h8000 or 16'h7FFF.
- `FIR_SATURATE_EN` undefined: the rounded result is truncated to its low 16 bits (two's-complement wrap).

## Structure
- Package `fir_pkg` holds:
  - `DATA_W`, `COEF_W`, `TAPS`, and the accumulator width `ACC_W`=38.
  - `COEFFS`, an array of `TAPS` signed `COEF_W` localparams.
  - A shared signed sample typedef.
- Sub-module `fir_round_sat` takes the `ACC_W` input and produces the 16-bit rounded, saturated or wrapped output. It contains the `FIR_SATURATE_EN` conditional.
- Top level `fir_filter` contains the delay line, pre-adders, multipliers, adder tree and output register.

## Test plan
- Reset: drive `filter_in`=16'h1234 with `rst_n`=0 for 2 edges, then `rst_n`=1. Required: `filter_out`=0 throughout reset and on the first enabled edge after it.
- Impulse: one sample of 16384, then zeros, `clk_en`=1. Required: `filter_out` equals round(h[k]/2) on successive edges, starting 2 edges after capture, for k=0..30. It then returns to 0 and the sequence is symmetric.
- DC: constant 1000 with `clk_en`=1. Required: after 33 enabled edges, `filter_out`=1000 exactly and stays there.
- Enable gating: during an impulse response, hold `clk_en`=0 for 5 cycles. Required: `filter_out` holds its value, and the remaining sequence resumes with no sample lost or duplicated.
- Saturation: drive x=+32767 where h≥0 and −32768 where h<0, aligned to fill the delay line. Required: `filter_out`=16'h7FFF with `FIR_SATURATE_EN`; with the macro undefined, the low 16 bits of the rounded sum.
- Mid-stream reset: pulse `rst_n`=0 for 1 edge during DC input. Required: `filter_out`=0 on the next edge, then the DC response restarts from zero history.
